// File: rtl/lsh_pkg.sv
// Shared defaults, storage types and FSM encoding for the LSH bucket store.
package lsh_pkg;

    localparam int LSH_SKETCH_SIZE         = 16;
    localparam int LSH_NUM_OF_BUCKETS      = 256;
    localparam int LSH_LOG2_NUM_OF_BUCKETS = 8;
    localparam int LSH_BUCKET_SIZE         = 16;
    localparam int LSH_MAX_WINDOWS         = 1024;

    localparam int LSH_WIN_ID_W = $clog2(LSH_MAX_WINDOWS);
    localparam int LSH_FILL_W   = $clog2(LSH_BUCKET_SIZE) + 1;

    typedef logic [LSH_LOG2_NUM_OF_BUCKETS-1:0] bucket_idx_t;
    typedef logic [LSH_WIN_ID_W-1:0]            win_id_t;
    typedef logic [LSH_FILL_W-1:0]              fill_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INSERT = 2'd1,
        QUERY  = 2'd2
    } lsh_state_e;

endpackage

// File: rtl/lsh_bucket_mem.sv
// Bucket entry array with per-bucket fill counters: one append-style write port,
// one combinational read port returning a whole bucket plus its fill level.
module lsh_bucket_mem
    import lsh_pkg::*;
#(
    parameter int NUM_BUCKETS = LSH_NUM_OF_BUCKETS,
    parameter int BUCKET_SIZE = LSH_BUCKET_SIZE,
    parameter int IDX_W       = LSH_LOG2_NUM_OF_BUCKETS,
    parameter int ID_W        = LSH_WIN_ID_W,
    parameter int FILL_W      = $clog2(BUCKET_SIZE) + 1
) (
    input  logic                              clk,
    input  logic                              rst_i,
    input  logic                              wr_en_i,
    input  logic [IDX_W-1:0]                  wr_bucket_i,
    input  logic [ID_W-1:0]                   wr_id_i,
    input  logic [IDX_W-1:0]                  rd_bucket_i,
    output logic [BUCKET_SIZE-1:0][ID_W-1:0]  rd_entries_o,
    output logic [FILL_W-1:0]                 rd_fill_o
);

    localparam int SLOT_W = $clog2(BUCKET_SIZE);

    logic [ID_W-1:0]   entry_q [NUM_BUCKETS][BUCKET_SIZE];
    logic [FILL_W-1:0] fill_q  [NUM_BUCKETS];
    logic [FILL_W-1:0] wr_fill;
    logic              wr_ok;

    // A full bucket silently drops the write; nothing wraps or overwrites.
    assign wr_fill = fill_q[wr_bucket_i];
    assign wr_ok   = wr_en_i && (wr_fill < FILL_W'(BUCKET_SIZE));

    always_ff @(posedge clk) begin
        if (rst_i) begin
            for (int b = 0; b < NUM_BUCKETS; b++) begin
                fill_q[b] <= '0;
            end
        end else if (wr_ok) begin
            fill_q[wr_bucket_i] <= wr_fill + FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            entry_q[wr_bucket_i][wr_fill[SLOT_W-1:0]] <= wr_id_i;
        end
    end

    always_comb begin
        for (int s = 0; s < BUCKET_SIZE; s++) begin
            rd_entries_o[s] = entry_q[rd_bucket_i][s];
        end
    end

    assign rd_fill_o = fill_q[rd_bucket_i];

endmodule

// File: rtl/lsh_hash_table.sv
// LSH bucket store: inserts window IDs into sketch-addressed buckets and counts
// per-window bucket hits for a query sketch. Optional macro: LSH_HT_DEDUP_EN.
module lsh_hash_table
    import lsh_pkg::*;
#(
    parameter int SKETCH_SIZE              = LSH_SKETCH_SIZE,
    parameter int NUM_OF_BUCKETS           = LSH_NUM_OF_BUCKETS,
    parameter int LOG2_NUM_OF_BUCKETS      = LSH_LOG2_NUM_OF_BUCKETS,
    parameter int BUCKET_SIZE              = LSH_BUCKET_SIZE,
    parameter int MAX_WINDOWS_IN_REFERENCE = LSH_MAX_WINDOWS
) (
    input  logic                                                 clk,
    input  logic                                                 reset_hash_table,
    input  logic                                                 is_insert,
    input  logic                                                 is_query,
    input  logic [31:0]                                          window_id,
    input  logic [SKETCH_SIZE-1:0][LOG2_NUM_OF_BUCKETS-1:0]      hashed_sketch,
    output logic [MAX_WINDOWS_IN_REFERENCE-1:0][31:0]            count_bus,
    output logic                                                 busy,
    output logic                                                 done
);

    localparam int ID_W   = $clog2(MAX_WINDOWS_IN_REFERENCE);
    localparam int FILL_W = $clog2(BUCKET_SIZE) + 1;
    localparam int IDX_W  = $clog2(SKETCH_SIZE);
    localparam int HIT_W  = $clog2(BUCKET_SIZE + 1);
    localparam int CNT_W  = 32;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [HIT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    lsh_state_e state_q, state_d;
    logic [IDX_W-1:0]                                   idx_q, idx_d;
    logic [SKETCH_SIZE-1:0][LOG2_NUM_OF_BUCKETS-1:0]    sketch_q, sketch_d;
    logic [ID_W-1:0]                                    id_q, id_d;
    logic                                               id_ok_q, id_ok_d;
    logic                                               done_q, done_d;
    logic [MAX_WINDOWS_IN_REFERENCE-1:0][CNT_W-1:0]     count_q, count_d;

    logic                                   clr_counts;
    logic                                   wr_en;
    logic                                   dup;
    logic [LOG2_NUM_OF_BUCKETS-1:0]         cur_bucket;
    logic [BUCKET_SIZE-1:0][ID_W-1:0]       rd_entries;
    logic [FILL_W-1:0]                      rd_fill;
    logic [HIT_W-1:0]                       hits;

    assign cur_bucket = sketch_q[idx_q];

    lsh_bucket_mem #(
        .NUM_BUCKETS (NUM_OF_BUCKETS),
        .BUCKET_SIZE (BUCKET_SIZE),
        .IDX_W       (LOG2_NUM_OF_BUCKETS),
        .ID_W        (ID_W),
        .FILL_W      (FILL_W)
    ) u_mem (
        .clk          (clk),
        .rst_i        (reset_hash_table),
        .wr_en_i      (wr_en),
        .wr_bucket_i  (cur_bucket),
        .wr_id_i      (id_q),
        .rd_bucket_i  (cur_bucket),
        .rd_entries_o (rd_entries),
        .rd_fill_o    (rd_fill)
    );

`ifdef LSH_HT_DEDUP_EN
    logic [FILL_W-1:0] last_slot;
    assign last_slot = rd_fill - FILL_W'(1);
    assign dup = (rd_fill != '0) && (rd_entries[last_slot[FILL_W-2:0]] == id_q);
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sketch_d   = sketch_q;
        id_d       = id_q;
        id_ok_d    = id_ok_q;
        done_d     = 1'b0;
        clr_counts = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                // Insert has priority when both commands arrive together.
                if (is_insert || is_query) begin
                    state_d    = is_insert ? INSERT : QUERY;
                    idx_d      = '0;
                    sketch_d   = hashed_sketch;
                    id_d       = window_id[ID_W-1:0];
                    id_ok_d    = (window_id < 32'(MAX_WINDOWS_IN_REFERENCE));
                    clr_counts = !is_insert;
                end
            end
            INSERT, QUERY: begin
                wr_en = (state_q == INSERT) && id_ok_q && !dup;
                if (idx_q == IDX_W'(SKETCH_SIZE - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Each query cycle adds, per window, the number of matching slots in one bucket.
    always_comb begin
        count_d = count_q;
        hits    = '0;
        if (clr_counts) begin
            count_d = '0;
        end else if (state_q == QUERY) begin
            for (int w = 0; w < MAX_WINDOWS_IN_REFERENCE; w++) begin
                hits = '0;
                for (int s = 0; s < BUCKET_SIZE; s++) begin
                    if ((FILL_W'(s) < rd_fill) && (rd_entries[s] == ID_W'(w))) begin
                        hits = hits + HIT_W'(1);
                    end
                end
                count_d[w] = sat_add(count_q[w], hits);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_hash_table) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        sketch_q <= sketch_d;
        id_q     <= id_d;
        id_ok_q  <= id_ok_d;
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign count_bus = count_q;

endmodule

// File: tb/tb_lsh_hash_table.sv
// Self-checking bench for lsh_hash_table against a queue-per-bucket reference model.
module tb_lsh_hash_table;

    typedef logic [15:0][7:0] sk_t;

`ifdef LSH_HT_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_hash_table;
    logic              is_insert;
    logic              is_query;
    logic [31:0]       window_id;
    sk_t               hashed_sketch;
    logic [1023:0][31:0] count_bus;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    int unsigned bkt[256][$];
    int unsigned mcount[1024];

    lsh_hash_table dut (
        .clk              (clk),
        .reset_hash_table (reset_hash_table),
        .is_insert        (is_insert),
        .is_query         (is_query),
        .window_id        (window_id),
        .hashed_sketch    (hashed_sketch),
        .count_bus        (count_bus),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    function automatic sk_t sk_all(input int v);
        sk_t s;
        for (int e = 0; e < 16; e++) s[e] = 8'(v);
        return s;
    endfunction

    function automatic sk_t sk_rand(input int hi);
        sk_t s;
        for (int e = 0; e < 16; e++) s[e] = 8'($urandom_range(0, hi));
        return s;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 256; b++) bkt[b].delete();
        for (int w = 0; w < 1024; w++) mcount[w] = 0;
    endtask

    task automatic model_insert(input logic [31:0] id, input sk_t sk);
        int b;
        if (id < 1024) begin
            for (int e = 0; e < 16; e++) begin
                b = int'(sk[e]);
                if (bkt[b].size() < 16) begin
                    if (!(DEDUP && bkt[b].size() > 0 && bkt[b][bkt[b].size()-1] == id))
                        bkt[b].push_back(id);
                end
            end
        end
    endtask

    task automatic model_query(input sk_t sk);
        int b;
        for (int w = 0; w < 1024; w++) mcount[w] = 0;
        for (int e = 0; e < 16; e++) begin
            b = int'(sk[e]);
            foreach (bkt[b][i]) begin
                if (mcount[bkt[b][i]] != 32'hFFFF_FFFF) mcount[bkt[b][i]]++;
            end
        end
    endtask

    task automatic compare_counts(input string name);
        int bad = 0;
        int first = -1;
        for (int w = 0; w < 1024; w++) begin
            if (count_bus[w] !== mcount[w]) begin
                bad++;
                if (first < 0) first = w;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s count_bus: %0d entries differ, first w=%0d got %0d want %0d",
                     name, bad, first, count_bus[first], mcount[first]);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_hash_table = 1'b1;
        is_insert = 1'b0;
        is_query  = 1'b0;
        @(negedge clk);
        reset_hash_table = 1'b0;
        model_clear();
    endtask

    // Issues one command, checks busy/done timing, updates the model and, for
    // queries, compares the whole count_bus. inject>0 pulses a command while busy.
    task automatic run_cmd(input string name, input bit ins, input bit qry,
                           input logic [31:0] id, input sk_t sk, input int inject);
        int lat;
        bit seen;
        bit busy_bad;
        @(negedge clk);
        is_insert = ins;
        is_query  = qry;
        window_id = id;
        hashed_sketch = sk;
        @(negedge clk);
        is_insert = 1'b0;
        is_query  = 1'b0;
        window_id = $urandom;
        hashed_sketch = sk_rand(255);
        lat = 1;
        seen = 1'b0;
        busy_bad = 1'b0;
        while (!seen && lat <= 40) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_bad = 1'b1;
                if (lat == inject) begin
                    is_insert = 1'b1;
                    is_query  = 1'b1;
                    window_id = 32'd9;
                    hashed_sketch = sk;
                end
                @(negedge clk);
                is_insert = 1'b0;
                is_query  = 1'b0;
                lat++;
            end
        end
        checks++;
        if (!seen || lat != 17) begin
            errors++;
            $display("FAIL %s done_latency: got %0d (seen=%0d) want 17", name, lat, seen);
        end
        checks++;
        if (busy_bad || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: low during op=%0d, at done=%b want 1 then 0", name, busy_bad, busy);
        end
        if (ins) model_insert(id, sk);
        else if (qry) model_query(sk);
        if (qry && !ins) compare_counts(name);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse_width: got %b want 0", name, done);
        end
    endtask

    task automatic test_reset();
        int nz = 0;
        for (int w = 0; w < 1024; w++) if (count_bus[w] !== 32'd0) nz++;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        checks++;
        if (nz != 0) begin errors++; $display("FAIL reset counts: %0d nonzero want 0", nz); end
    endtask

    task automatic test_query_empty();
        run_cmd("query_empty", 1'b0, 1'b1, 32'd0, sk_all(5), 0);
    endtask

    task automatic test_insert_query();
        sk_t s;
        pulse_reset();
        for (int e = 0; e < 16; e++) s[e] = 8'(e);
        run_cmd("ins_ramp", 1'b1, 1'b0, 32'd3, s, 0);
        run_cmd("qry_ramp", 1'b0, 1'b1, 32'd0, s, 0);
        checks++;
        if (count_bus[3] !== 32'd16) begin
            errors++;
            $display("FAIL qry_ramp count3: got %0d want 16", count_bus[3]);
        end
    endtask

    task automatic test_repeat_bucket();
        sk_t s;
        pulse_reset();
        run_cmd("ins_rep", 1'b1, 1'b0, 32'd7, sk_all(9), 0);
        s = sk_all(0);
        s[0] = 8'd9;
        run_cmd("qry_rep", 1'b0, 1'b1, 32'd0, s, 0);
        checks++;
        if (count_bus[7] !== (DEDUP ? 32'd1 : 32'd16)) begin
            errors++;
            $display("FAIL qry_rep count7: got %0d want %0d", count_bus[7], DEDUP ? 1 : 16);
        end
    endtask

    task automatic test_overflow();
        sk_t s;
        pulse_reset();
        for (int i = 0; i <= 16; i++) run_cmd("ins_ovf", 1'b1, 1'b0, 32'(i), sk_all(2), 0);
        s = sk_all(3);
        s[0] = 8'd2;
        run_cmd("qry_ovf", 1'b0, 1'b1, 32'd0, s, 0);
        checks++;
        if (count_bus[16] !== 32'd0 || count_bus[0] !== (DEDUP ? 32'd1 : 32'd16)) begin
            errors++;
            $display("FAIL qry_ovf ids: id16 got %0d want 0, id0 got %0d want %0d",
                     count_bus[16], count_bus[0], DEDUP ? 1 : 16);
        end
    endtask

    task automatic test_priority_busy();
        sk_t s;
        pulse_reset();
        run_cmd("ins_both", 1'b1, 1'b1, 32'd4, sk_all(1), 5);
        s = sk_all(0);
        s[0] = 8'd1;
        run_cmd("qry_both", 1'b0, 1'b1, 32'd0, s, 7);
        checks++;
        if (count_bus[4] !== (DEDUP ? 32'd1 : 32'd16) || count_bus[9] !== 32'd0) begin
            errors++;
            $display("FAIL qry_both ids: id4 got %0d want %0d, id9 got %0d want 0",
                     count_bus[4], DEDUP ? 1 : 16, count_bus[9]);
        end
    endtask

    task automatic test_reset_mid_op();
        int nz = 0;
        pulse_reset();
        run_cmd("ins_pre", 1'b1, 1'b0, 32'd5, sk_all(0), 0);
        run_cmd("qry_pre", 1'b0, 1'b1, 32'd0, sk_all(0), 0);
        @(negedge clk);
        is_insert = 1'b1;
        window_id = 32'd6;
        hashed_sketch = sk_all(0);
        @(negedge clk);
        is_insert = 1'b0;
        repeat (4) @(negedge clk);
        reset_hash_table = 1'b1;
        @(negedge clk);
        reset_hash_table = 1'b0;
        model_clear();
        for (int w = 0; w < 1024; w++) if (count_bus[w] !== 32'd0) nz++;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || nz != 0) begin
            errors++;
            $display("FAIL mid_reset state: busy=%b done=%b nonzero=%0d want 0 0 0", busy, done, nz);
        end
        run_cmd("qry_post", 1'b0, 1'b1, 32'd0, sk_all(0), 0);
        run_cmd("ins_bad_id", 1'b1, 1'b0, 32'd2000, sk_all(0), 0);
        run_cmd("qry_bad_id", 1'b0, 1'b1, 32'd0, sk_all(0), 0);
        checks++;
        if (count_bus[976] !== 32'd0) begin
            errors++;
            $display("FAIL qry_bad_id count976: got %0d want 0", count_bus[976]);
        end
    endtask

    task automatic test_random();
        logic [31:0] id;
        pulse_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                id = ($urandom_range(0, 7) == 0) ? 32'(1024 + $urandom_range(0, 5000))
                                                 : 32'($urandom_range(0, 31));
                run_cmd("ins_rand", 1'b1, $urandom_range(0, 1) == 1, id, sk_rand(7), 0);
            end
            run_cmd("qry_rand", 1'b0, 1'b1, 32'd0, sk_rand(7), 0);
            run_cmd("qry_rand2", 1'b0, 1'b1, 32'd0, sk_rand(9), 0);
        end
    endtask

    initial begin
        reset_hash_table = 1'b1;
        is_insert = 1'b0;
        is_query  = 1'b0;
        window_id = '0;
        hashed_sketch = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset_hash_table = 1'b0;
        test_reset();
        test_query_empty();
        test_insert_query();
        test_repeat_bucket();
        test_overflow();
        test_priority_busy();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
